seq_divider: RTL

Sequential restoring divider, the inverse companion to the Vedic multiplier family. It takes a 2W-bit dividend and a W-bit divisor and returns a 2W-bit quotient and a W-bit remainder. Default W=256, so a full 512-bit Vedic256 product divided by one 256-bit operand recovers the other. It is used as a self-check / inverse-operation unit beside the multipliers, with valid/ready handshakes on both sides.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_step.sv | 38 +++
 rtl/seq_divider.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and sizing helpers for the sequential divider
//
// Contents:
//   DEFAULT_W    default divisor/remainder width (dividend/quotient are 2*W)
//   div_state_e  controller states IDLE / BUSY / DONE
//   cnt_width()  step-counter width, $clog2(2*W)+1, so the counter can hold 2*W

package divider_pkg;

  localparam int DEFAULT_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   pr_in    [W:0]    partial remainder before the step
//   bit_in            next dividend bit (MSB first)
//   divisor  [W-1:0]  latched divisor
//   pr_out   [W:0]    partial remainder after the step
//   qbit              quotient bit produced by this step

module div_step
  import divider_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W:0]   pr_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   pr_out,
  output logic         qbit
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       ge;

  assign shifted = {pr_in[W-1:0], bit_in};
  assign diff    = shifted - {1'b0, divisor};

  // The true shifted value is {pr_in, bit_in}; a set pr_in[W] would make it
  // at least 2^(W+1) and hence larger than any divisor. The stored remainder
  // is always below the divisor so that bit stays clear, but folding it in
  // keeps the comparison exact at W+1 bits without special cases.
  assign ge = pr_in[W] | (shifted >= {1'b0, divisor});

  assign qbit   = ge;
  assign pr_out = ge ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, 2W-bit by W-bit, valid/ready both sides
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; operands sampled on the accept edge only
//   dividend  [2W-1:0]    unsigned numerator
//   divisor   [W-1:0]     unsigned denominator
//   out_valid / out_ready result handshake; outputs hold while out_ready is low
//   quotient  [2W-1:0]    floor(dividend / divisor)
//   remainder [W-1:0]     dividend mod divisor
//   div_zero              divisor was zero (only with DIV_ZERO_DETECT_EN)
//
// Build option: DIV_ZERO_DETECT_EN - a zero divisor skips the iteration and
// reports div_zero; without it div_zero is tied low and the full 2W steps run.

module seq_divider
  import divider_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero
);

  localparam int               CNT_W     = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * W - 1);

  div_state_e state, state_nxt;

  logic [2*W-1:0] dvd_sr;
  logic [2*W-1:0] quo;
  logic [W-1:0]   dvs;
  logic [W:0]     pr;
  logic [CNT_W-1:0] count;

  logic [W:0] step_pr;
  logic       step_qbit;
  logic       zero_fast;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(
    .W (W)
  ) u_step (
    .pr_in   (pr),
    .bit_in  (dvd_sr[2*W-1]),
    .divisor (dvs),
    .pr_out  (step_pr),
    .qbit    (step_qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = zero_fast ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: dividend shifts out MSB-first while quotient bits shift in at
  // the LSB, so after 2W steps quo holds the full quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sr <= '0;
      dvs    <= '0;
      pr     <= '0;
      quo    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs   <= divisor;
            count <= '0;
            if (zero_fast) begin
              // Same values the full iteration would produce for a zero divisor
              dvd_sr <= '0;
              quo    <= '1;
              pr     <= {1'b0, dividend[W-1:0]};
            end else begin
              dvd_sr <= dividend;
              quo    <= '0;
              pr     <= '0;
            end
          end
        end
        BUSY: begin
          dvd_sr <= {dvd_sr[2*W-2:0], 1'b0};
          quo    <= {quo[2*W-2:0], step_qbit};
          pr     <= step_pr;
          count  <= count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      dz_q <= zero_fast;
    end else if (state == DONE && out_ready) begin
      dz_q <= 1'b0;
    end
  end

  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign quotient  = quo;
  assign remainder = pr[W-1:0];

endmodule
